two_d_filter: RTL and testbench
===============================

TWO_D_FILTER -- requirements
Module: two_d_filter

Interface
REQ-001 Parameter DATA_W, default 30: pixel and output width.
REQ-002 Parameter COEF_W, default 9: coefficient width.
REQ-003 Parameter LINE_W, default 1280: pixels per image line, which is the line-buffer depth; minimum 2.
REQ-004 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 Port aclr, input, 1: reset, asynchronous and active-high.
REQ-006 Port data_valid_in, input, 1: data holds a valid pixel this cycle.
REQ-007 Port data, input, DATA_W: pixel value, unsigned.
REQ-008 Ports coef1_1..coef3_3, input, COEF_W each: unsigned tap coefficients, where coefR_C pairs with window position R,C.
REQ-009 Ports row1_1..row3_3, output, DATA_W each: the 3x3 window taps, or weighted taps (see Configuration).
REQ-010 Port data_valid_out, output, 1: the row outputs were updated for an accepted pixel.

Function
REQ-011 The block SHALL advance only on cycles with data_valid_in=1; with data_valid_in=0, all state holds.
REQ-012 The block SHALL contain two cascaded line buffers, each a LINE_W-deep pixel delay advanced only on valid cycles.
REQ-013 Window row 3 SHALL take data, row 2 SHALL take the first line-buffer output (data from LINE_W valid pixels earlier), and row 1 SHALL take the second line-buffer output (2*LINE_W valid pixels earlier).
REQ-014 Each window row SHALL be a 3-stage shift: column 3 is the newest pixel, column 2 the previous one, column 1 the oldest.
REQ-015 The window registers SHALL update on the same clock edge that accepts the pixel.
REQ-016 No line-edge or frame-edge handling: the window spans line boundaries unmodified, and pixel counting continues across frames.
REQ-017 data_valid_out SHALL equal data_valid_in delayed by exactly the output latency: 1 cycle in raw mode, 2 cycles in weighted mode.
REQ-018 Back-to-back valid cycles SHALL be accepted at one pixel per clock, with no stall and no ready signal.

Reset
REQ-019 While aclr=1, the window registers, line-buffer contents, multiplier pipeline registers, all row outputs and data_valid_out SHALL be 0, asynchronously.
REQ-020 After aclr deasserts, the first accepted pixel SHALL see zeros in all older window positions.
REQ-021 Asserting aclr mid-frame SHALL discard all buffered pixels; there is no partial recovery.

Configuration
REQ-022 Macro TWO_D_FILTER_COEF_EN SHALL select the output mode.
REQ-023 With TWO_D_FILTER_COEF_EN defined (weighted mode): rowR_C SHALL equal windowR_C * coefR_C, registered once, low DATA_W bits kept, unsigned.
REQ-024 Without TWO_D_FILTER_COEF_EN (raw mode): rowR_C SHALL equal windowR_C, the coefficient inputs are ignored, and no multipliers are built.

Structure
REQ-025 Package two_d_filter_pkg SHALL hold the DATA_W, COEF_W and LINE_W defaults and the output-latency constants (1 and 2).
REQ-026 The line buffer SHALL be a sub-module named line_buffer, with ports clk, aclr, en, din and dout and a DEPTH parameter, instantiated twice.

Verification
REQ-027 Reset: LINE_W=4, drive data and valid with aclr=1 -> all outputs are 0 and data_valid_out is 0.
REQ-028 Window fill, raw mode, LINE_W=4: feed 1..11 on consecutive valid cycles -> after 11 is accepted, row3 = 9,10,11, row2 = 5,6,7, row1 = 1,2,3, and data_valid_out pulses 1 cycle after each valid.
REQ-029 Gaps: the same stream as REQ-028 with a random number of invalid cycles (1-3) between pixels -> identical window values after each accepted pixel, and outputs hold during gaps.
REQ-030 Weighted mode: coefR_C = 2, stream as in REQ-028 -> after the 2-cycle latency row3_3 = 22 and row1_1 = 2.
REQ-031 Truncation: data = 2^30-1 and coef = 511 -> the output is the low 30 bits of the product.
REQ-032 Mid-stream reset: pulse aclr after pixel 6, then feed 20 -> row3_3 = 20 and every other tap = 0.

Source files
------------

// File: rtl/two_d_filter_pkg.sv
// Shared defaults and latency constants for the 3x3 window filter.
package two_d_filter_pkg;

  localparam int unsigned DATA_W_DEF = 30;
  localparam int unsigned COEF_W_DEF = 9;
  localparam int unsigned LINE_W_DEF = 1280;

  // Window geometry (rows x columns).
  localparam int unsigned TAPS = 3;

  // Output latency in clock cycles from an accepted pixel to data_valid_out.
  localparam int unsigned LAT_RAW      = 1;
  localparam int unsigned LAT_WEIGHTED = 2;

endpackage

// File: rtl/two_d_filter_line_buffer.sv
// line_buffer: DEPTH-deep pixel delay that shifts only when en is high.
// Contents clear asynchronously so a reset discards every buffered pixel.
module line_buffer #(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned DEPTH = 1280
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Shift chain; mem[DEPTH-1] holds the pixel accepted DEPTH enables ago.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (en) begin
      mem[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/two_d_filter.sv
// two_d_filter: 3x3 sliding window over a raster stream built from two
// cascaded line buffers. Macro TWO_D_FILTER_COEF_EN selects weighted
// output (window tap * coefficient, registered once); otherwise the raw
// window taps are driven out directly.
module two_d_filter
  import two_d_filter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              data_valid_in,
  input  logic [DATA_W-1:0] data,
  input  logic [COEF_W-1:0] coef1_1,
  input  logic [COEF_W-1:0] coef1_2,
  input  logic [COEF_W-1:0] coef1_3,
  input  logic [COEF_W-1:0] coef2_1,
  input  logic [COEF_W-1:0] coef2_2,
  input  logic [COEF_W-1:0] coef2_3,
  input  logic [COEF_W-1:0] coef3_1,
  input  logic [COEF_W-1:0] coef3_2,
  input  logic [COEF_W-1:0] coef3_3,
  output logic [DATA_W-1:0] row1_1,
  output logic [DATA_W-1:0] row1_2,
  output logic [DATA_W-1:0] row1_3,
  output logic [DATA_W-1:0] row2_1,
  output logic [DATA_W-1:0] row2_2,
  output logic [DATA_W-1:0] row2_3,
  output logic [DATA_W-1:0] row3_1,
  output logic [DATA_W-1:0] row3_2,
  output logic [DATA_W-1:0] row3_3,
  output logic              data_valid_out
);

`ifdef TWO_D_FILTER_COEF_EN
  localparam int unsigned OUT_LAT = LAT_WEIGHTED;
`else
  localparam int unsigned OUT_LAT = LAT_RAW;
`endif

  logic [DATA_W-1:0]  lb1_dout;
  logic [DATA_W-1:0]  lb2_dout;
  logic [DATA_W-1:0]  row_in [TAPS];
  logic [DATA_W-1:0]  win    [TAPS][TAPS];
  logic [DATA_W-1:0]  taps   [TAPS][TAPS];
  logic [OUT_LAT-1:0] vld_pipe;

  line_buffer #(
    .WIDTH (DATA_W),
    .DEPTH (LINE_W)
  ) u_lb1 (
    .clk  (clk),
    .aclr (aclr),
    .en   (data_valid_in),
    .din  (data),
    .dout (lb1_dout)
  );

  line_buffer #(
    .WIDTH (DATA_W),
    .DEPTH (LINE_W)
  ) u_lb2 (
    .clk  (clk),
    .aclr (aclr),
    .en   (data_valid_in),
    .din  (lb1_dout),
    .dout (lb2_dout)
  );

  // Row feeds: oldest line on row 1, current pixel on row 3.
  always_comb begin
    row_in[0] = lb2_dout;
    row_in[1] = lb1_dout;
    row_in[2] = data;
  end

  // Window shift: column 3 takes the new pixel, older columns move left.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int unsigned r = 0; r < TAPS; r++) begin
        for (int unsigned c = 0; c < TAPS; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (data_valid_in) begin
      for (int unsigned r = 0; r < TAPS; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
        win[r][2] <= row_in[r];
      end
    end
  end

  // Valid delay line matching the output latency of the selected mode.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= data_valid_in;
      for (int unsigned i = 1; i < OUT_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign data_valid_out = vld_pipe[OUT_LAT-1];

`ifdef TWO_D_FILTER_COEF_EN
  logic [COEF_W-1:0] coef [TAPS][TAPS];
  logic [DATA_W-1:0] prod [TAPS][TAPS];

  // Coefficient ports gathered into the same layout as the window.
  always_comb begin
    coef[0][0] = coef1_1;
    coef[0][1] = coef1_2;
    coef[0][2] = coef1_3;
    coef[1][0] = coef2_1;
    coef[1][1] = coef2_2;
    coef[1][2] = coef2_3;
    coef[2][0] = coef3_1;
    coef[2][1] = coef3_2;
    coef[2][2] = coef3_3;
  end

  // Weighted taps, registered once and only for a freshly updated window;
  // only the low DATA_W bits of each product are kept, so both operands
  // are taken at DATA_W width.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int unsigned r = 0; r < TAPS; r++) begin
        for (int unsigned c = 0; c < TAPS; c++) begin
          prod[r][c] <= '0;
        end
      end
    end else if (vld_pipe[0]) begin
      for (int unsigned r = 0; r < TAPS; r++) begin
        for (int unsigned c = 0; c < TAPS; c++) begin
          prod[r][c] <= win[r][c] * DATA_W'(coef[r][c]);
        end
      end
    end
  end

  // Output taps come from the product registers.
  always_comb begin
    for (int unsigned r = 0; r < TAPS; r++) begin
      for (int unsigned c = 0; c < TAPS; c++) begin
        taps[r][c] = prod[r][c];
      end
    end
  end
`else
  logic coef_unused;
  assign coef_unused = ^{coef1_1, coef1_2, coef1_3,
                         coef2_1, coef2_2, coef2_3,
                         coef3_1, coef3_2, coef3_3};

  // Output taps are the window registers themselves.
  always_comb begin
    for (int unsigned r = 0; r < TAPS; r++) begin
      for (int unsigned c = 0; c < TAPS; c++) begin
        taps[r][c] = win[r][c];
      end
    end
  end
`endif

  assign row1_1 = taps[0][0];
  assign row1_2 = taps[0][1];
  assign row1_3 = taps[0][2];
  assign row2_1 = taps[1][0];
  assign row2_2 = taps[1][1];
  assign row2_3 = taps[1][2];
  assign row3_1 = taps[2][0];
  assign row3_2 = taps[2][1];
  assign row3_3 = taps[2][2];

endmodule

// File: tb/tb_two_d_filter.sv
// Bench for two_d_filter (LINE_W=4): a pixel-history model predicts every
// tap each cycle; directed literal checks pin the model. Honours
// TWO_D_FILTER_COEF_EN the same way the design does.
module tb_two_d_filter;

  localparam int unsigned DW = 30;
  localparam int unsigned CW = 9;
  localparam int unsigned LW = 4;

`ifdef TWO_D_FILTER_COEF_EN
  localparam bit WEIGHTED = 1'b1;
`else
  localparam bit WEIGHTED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          aclr = 1'b1;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic [CW-1:0] coef [9];
  logic [DW-1:0] row  [9];
  logic          vout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  two_d_filter #(
    .DATA_W (DW),
    .COEF_W (CW),
    .LINE_W (LW)
  ) dut (
    .clk            (clk),
    .aclr           (aclr),
    .data_valid_in  (valid),
    .data           (data),
    .coef1_1        (coef[0]),
    .coef1_2        (coef[1]),
    .coef1_3        (coef[2]),
    .coef2_1        (coef[3]),
    .coef2_2        (coef[4]),
    .coef2_3        (coef[5]),
    .coef3_1        (coef[6]),
    .coef3_2        (coef[7]),
    .coef3_3        (coef[8]),
    .row1_1         (row[0]),
    .row1_2         (row[1]),
    .row1_3         (row[2]),
    .row2_1         (row[3]),
    .row2_2         (row[4]),
    .row2_3         (row[5]),
    .row3_1         (row[6]),
    .row3_2         (row[7]),
    .row3_3         (row[8]),
    .data_valid_out (vout)
  );

  task automatic chk(input string name, input longint unsigned act,
                     input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist holds accepted pixels since reset (newest last). Window tap (r,c)
  // is the pixel (2-r)*LW + (2-c) accepts before the newest one.
  logic [DW-1:0] hist [$];
  logic [DW-1:0] mwin [9];
  logic [DW-1:0] mrow [9];
  bit            mv1;
  bit            mvout;

  function automatic logic [DW-1:0] tap(input int r, input int c);
    int idx;
    idx = hist.size() - 1 - ((2 - r) * int'(LW) + (2 - c));
    return (idx >= 0) ? hist[idx] : '0;
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int k = 0; k < 9; k++) begin
      mwin[k] = '0;
      mrow[k] = '0;
    end
    mv1   = 1'b0;
    mvout = 1'b0;
  endtask

  task automatic model_step();
    logic [63:0] p;
    if (WEIGHTED) begin
      if (mv1) begin
        for (int k = 0; k < 9; k++) begin
          p = 64'(mwin[k]) * 64'(coef[k]);
          mrow[k] = p[DW-1:0];
        end
      end
      mvout = mv1;
      mv1   = valid;
    end
    if (valid) begin
      hist.push_back(data);
      while (hist.size() > int'(2 * LW + 3)) hist.delete(0);
      for (int k = 0; k < 9; k++) mwin[k] = tap(k / 3, k % 3);
    end
    if (!WEIGHTED) begin
      mrow  = mwin;
      mvout = valid;
    end
  endtask

  // Compare process: advance the model at each edge, check at the falling edge.
  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      if (!aclr) model_step();
      @(negedge clk);
      if (aclr) model_clear();
      for (int k = 0; k < 9; k++) begin
        chk($sformatf("row%0d_%0d", k / 3 + 1, k % 3 + 1), row[k], mrow[k]);
      end
      chk("data_valid_out", vout, mvout);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [DW-1:0] v, input int gap);
    valid = 1'b1;
    data  = v;
    tick();
    valid = 1'b0;
    data  = DW'($urandom);
    repeat (gap) tick();
  endtask

  task automatic set_coefs(input logic [CW-1:0] v);
    for (int k = 0; k < 9; k++) coef[k] = v;
  endtask

  function automatic longint unsigned lit(input longint unsigned v);
    return WEIGHTED ? 2 * v : v;
  endfunction

  task automatic check_fill(input string tag);
    for (int k = 0; k < 9; k++) begin
      // Expected raw values: row1 1..3, row2 5..7, row3 9..11.
      chk($sformatf("%s_row%0d_%0d", tag, k / 3 + 1, k % 3 + 1), row[k],
          lit(longint'((k / 3) * 4 + (k % 3) + 1)));
    end
  endtask

  initial begin
    set_coefs(9'd2);

    // Reset held while data and valid toggle: everything must stay zero.
    repeat (3) begin
      valid = 1'b1;
      data  = DW'($urandom);
      tick();
    end
    chk("reset_row3_3", row[8], 0);
    chk("reset_row1_1", row[0], 0);
    chk("reset_valid", vout, 0);
    valid = 1'b0;
    aclr  = 1'b0;
    tick();

    // Back-to-back fill 1..11.
    for (int i = 1; i <= 11; i++) feed(DW'(i), 0);
    if (WEIGHTED) tick();
    check_fill("fill");
    chk("fill_row3_3_lit", row[8], WEIGHTED ? 22 : 11);
    chk("fill_row1_1_lit", row[0], WEIGHTED ? 2 : 1);

    // Same stream with 1-3 idle cycles between pixels.
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    for (int i = 1; i <= 11; i++) feed(DW'(i), int'($urandom_range(1, 3)));
    check_fill("gaps");

    // Mid-stream reset discards pixels 1..6.
    for (int i = 1; i <= 6; i++) feed(DW'(i), 0);
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    feed(DW'(20), 2);
    chk("midrst_row3_3", row[8], lit(20));
    for (int k = 0; k < 8; k++) chk($sformatf("midrst_tap%0d", k), row[k], 0);

    // Full-scale pixel against full-scale coefficient.
    set_coefs(9'd511);
    for (int i = 0; i < 3; i++) feed('1, 2);
    chk("trunc_row3_3", row[8], WEIGHTED ? 64'd1073741313 : 64'd1073741823);
    chk("trunc_row3_1", row[6], WEIGHTED ? 64'd1073741313 : 64'd1073741823);

    // Random traffic, coefficient changes and occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 2) aclr = 1'b1;
      else aclr = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < 9; k++) coef[k] = CW'($urandom);
      end
      valid = ($urandom_range(0, 9) < 7);
      data  = DW'($urandom);
      tick();
    end
    aclr  = 1'b0;
    valid = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
